// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch / load-store request channels, shared response and memory bus.
// master = arbiter view, slave = requesters/memory view.
`default_nettype none

interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              f_req_valid;
  logic              f_req_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic              f_resp_valid;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_write;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic [CNT_W-1:0]  fetch_wait_cnt;

  modport master (
    input  f_req_valid, f_req_addr, ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output f_req_ready, f_resp_valid, ls_req_ready, ls_resp_valid, resp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, fetch_wait_cnt
  );

  modport slave (
    output f_req_valid, f_req_addr, ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  f_req_ready, f_resp_valid, ls_req_ready, ls_resp_valid, resp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, fetch_wait_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (fetch, load/store) single-outstanding memory arbiter.
// Define MEM_ARB_FETCH_PRIORITY_EN for fixed fetch priority on ties; default is round-robin.
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner_ls;
  logic              r_last_ls;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_f_resp_valid;
  logic              r_ls_resp_valid;
  logic [CNT_W-1:0]  r_fetch_wait_cnt;

  logic w_tie_f;
  logic w_grant_f;
  logic w_grant_ls;
  logic w_resp_take;

`ifdef MEM_ARB_FETCH_PRIORITY_EN
  assign w_tie_f = 1'b1;
`else
  // Fetch wins a tie only when load/store held the bus last.
  assign w_tie_f = r_last_ls;
`endif

  assign w_grant_f   = (r_state == IDLE) && bus.f_req_valid && (!bus.ls_req_valid || w_tie_f);
  assign w_grant_ls  = (r_state == IDLE) && bus.ls_req_valid && !w_grant_f;
  assign w_resp_take = (r_state == WAIT_RESP) && bus.mem_resp_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_grant_f || w_grant_ls) w_next_state = ISSUE;
      ISSUE:     if (bus.mem_req_ready)       w_next_state = WAIT_RESP;
      WAIT_RESP: if (bus.mem_resp_valid)      w_next_state = IDLE;
      default:                                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_ls       <= 1'b0;
      r_last_ls        <= 1'b1;
      r_write          <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_resp_data      <= '0;
      r_f_resp_valid   <= 1'b0;
      r_ls_resp_valid  <= 1'b0;
      r_fetch_wait_cnt <= '0;
    end else begin
      r_f_resp_valid  <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      if (w_grant_f) begin
        r_owner_ls <= 1'b0;
        r_write    <= 1'b0;
        r_addr     <= bus.f_req_addr;
        r_wdata    <= '0;
      end else if (w_grant_ls) begin
        r_owner_ls <= 1'b1;
        r_write    <= bus.ls_req_write;
        r_addr     <= bus.ls_req_addr;
        r_wdata    <= bus.ls_req_wdata;
      end
      if (w_resp_take) begin
        r_resp_data     <= bus.mem_resp_data;
        r_f_resp_valid  <= !r_owner_ls;
        r_ls_resp_valid <= r_owner_ls;
        r_last_ls       <= r_owner_ls;
      end
      if (bus.f_req_valid && !w_grant_f && (r_fetch_wait_cnt != {CNT_W{1'b1}}))
        r_fetch_wait_cnt <= r_fetch_wait_cnt + 1'b1;
    end
  end

  assign bus.f_req_ready    = w_grant_f;
  assign bus.ls_req_ready   = w_grant_ls;
  assign bus.f_resp_valid   = r_f_resp_valid;
  assign bus.ls_resp_valid  = r_ls_resp_valid;
  assign bus.resp_data      = r_resp_data;
  assign bus.mem_req_valid  = (r_state == ISSUE);
  assign bus.mem_req_write  = r_write;
  assign bus.mem_req_addr   = r_addr;
  assign bus.mem_req_wdata  = r_wdata;
  assign bus.fetch_wait_cnt = r_fetch_wait_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter.
`default_nettype none

module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   total = 0;
  int   bad   = 0;
  int   hs    = 0;
  logic exp_f;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64), .CNT_W(32)) bus ();
  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64), .CNT_W(2))  bus2 ();

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  always @(posedge clk) if (bus.mem_req_valid && bus.mem_req_ready) hs++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bus.f_req_valid = 0; bus.f_req_addr = '0;
    bus.ls_req_valid = 0; bus.ls_req_write = 0; bus.ls_req_addr = '0; bus.ls_req_wdata = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
    bus2.f_req_valid = 1; bus2.f_req_addr = 64'h8;
    bus2.ls_req_valid = 0; bus2.ls_req_write = 0; bus2.ls_req_addr = '0; bus2.ls_req_wdata = '0;
    bus2.mem_req_ready = 0; bus2.mem_resp_valid = 0; bus2.mem_resp_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_f_ready",   bus.f_req_ready, 0);
    chk("rst_ls_ready",  bus.ls_req_ready, 0);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr",  bus.mem_req_addr, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_f_resp",    bus.f_resp_valid, 0);
    chk("rst_wait_cnt",  bus.fetch_wait_cnt, 0);
    chk("rst_sat_cnt",   bus2.fetch_wait_cnt, 0);
    reset = 1'b0; reset2 = 1'b0;

    // Single fetch read at 0x40
    bus.f_req_valid = 1; bus.f_req_addr = 64'h40; bus.mem_req_ready = 1;
    #1;
    chk("f_accept", bus.f_req_ready, 1);
    chk("f_accept_ls", bus.ls_req_ready, 0);
    tick(); bus.f_req_valid = 0; #1;
    chk("f_issue_valid", bus.mem_req_valid, 1);
    chk("f_issue_addr",  bus.mem_req_addr, 64'h40);
    chk("f_issue_write", bus.mem_req_write, 0);
    chk("f_issue_wdata", bus.mem_req_wdata, 0);
    chk("f_ready_low",   bus.f_req_ready, 0);
    tick();
    chk("f_wait_noval", bus.mem_req_valid, 0);
    tick(); tick();
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hDEADBEEF;
    tick(); bus.mem_resp_valid = 0; #1;
    chk("f_resp_valid", bus.f_resp_valid, 1);
    chk("f_resp_data",  bus.resp_data, 64'hDEADBEEF);
    chk("f_resp_ls",    bus.ls_resp_valid, 0);
    chk("f_one_hs",     hs, 1);
    tick();
    chk("f_resp_pulse", bus.f_resp_valid, 0);
    chk("f_wait_cnt",   bus.fetch_wait_cnt, 0);

    // Stray response in IDLE
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h1234;
    tick(); bus.mem_resp_valid = 0; #1;
    chk("stray_f_resp",  bus.f_resp_valid, 0);
    chk("stray_ls_resp", bus.ls_resp_valid, 0);
    chk("stray_data",    bus.resp_data, 64'hDEADBEEF);
    chk("stray_mem_val", bus.mem_req_valid, 0);

    // Tie arbitration after reset, both requesters always valid
    reset = 1'b1;
    bus.f_req_valid = 1; bus.f_req_addr = 64'h100;
    bus.ls_req_valid = 1; bus.ls_req_write = 0; bus.ls_req_addr = 64'h200;
    bus.mem_req_ready = 1;
    tick(); reset = 1'b0; #1;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_FETCH_PRIORITY_EN
      exp_f = 1'b1;
`else
      exp_f = (g % 2 == 0);
`endif
      chk("tie_grant_f",  bus.f_req_ready, exp_f);
      chk("tie_grant_ls", bus.ls_req_ready, !exp_f);
      tick();
      chk("tie_mem_addr", bus.mem_req_addr, exp_f ? 64'h100 : 64'h200);
      tick();
      bus.mem_resp_valid = 1; bus.mem_resp_data = 64'(g);
      tick(); bus.mem_resp_valid = 0; #1;
      chk("tie_resp_f",  bus.f_resp_valid, exp_f);
      chk("tie_resp_ls", bus.ls_resp_valid, !exp_f);
    end
`ifdef MEM_ARB_FETCH_PRIORITY_EN
    chk("tie_wait_cnt", bus.fetch_wait_cnt, 8);
`else
    chk("tie_wait_cnt", bus.fetch_wait_cnt, 10);
`endif
    bus.f_req_valid = 0; bus.ls_req_valid = 0; bus.mem_req_ready = 0;

    // Load/store write stalled 5 cycles, fetch waiting behind it
    reset = 1'b1; tick(); reset = 1'b0;
    bus.ls_req_valid = 1; bus.ls_req_write = 1; bus.ls_req_addr = 64'h1000; bus.ls_req_wdata = 64'h55;
    #1;
    chk("ls_accept", bus.ls_req_ready, 1);
    tick();
    bus.ls_req_valid = 0; bus.f_req_valid = 1; bus.f_req_addr = 64'h80;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", bus.mem_req_valid, 1);
      chk("stall_write", bus.mem_req_write, 1);
      chk("stall_addr",  bus.mem_req_addr, 64'h1000);
      chk("stall_wdata", bus.mem_req_wdata, 64'h55);
      chk("stall_fready", bus.f_req_ready, 0);
      tick();
    end
    chk("stall_wait_cnt", bus.fetch_wait_cnt, 5);
    bus.mem_req_ready = 1; #1;
    chk("stall_still_valid", bus.mem_req_valid, 1);
    tick(); bus.mem_req_ready = 0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'hAA;
    tick(); bus.mem_resp_valid = 0; #1;
    chk("ls_resp_valid", bus.ls_resp_valid, 1);
    chk("ls_resp_f",     bus.f_resp_valid, 0);
    chk("ls_resp_data",  bus.resp_data, 64'hAA);
    chk("ls_wait_cnt",   bus.fetch_wait_cnt, 7);
    chk("f_after_ls",    bus.f_req_ready, 1);
    bus.mem_req_ready = 1;
    tick(); bus.f_req_valid = 0; #1;
    chk("f2_addr", bus.mem_req_addr, 64'h80);
    tick();

    // Reset while waiting for the response, then a stray response
    reset = 1'b1; bus.mem_req_ready = 0; #1;
    chk("midrst_mem_valid", bus.mem_req_valid, 0);
    chk("midrst_wait_cnt",  bus.fetch_wait_cnt, 0);
    tick(); reset = 1'b0;
    bus.mem_resp_valid = 1; bus.mem_resp_data = 64'h77;
    tick(); bus.mem_resp_valid = 0; #1;
    chk("midrst_f_resp",  bus.f_resp_valid, 0);
    chk("midrst_ls_resp", bus.ls_resp_valid, 0);
    chk("midrst_data",    bus.resp_data, 0);
    chk("midrst_cnt",     bus.fetch_wait_cnt, 0);
    chk("midrst_mem_val", bus.mem_req_valid, 0);

    // Narrow counter saturates at all-ones
    chk("sat_cnt", bus2.fetch_wait_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, payload width.
REQ-003 SHALL have parameter CNT_W, default 32, fetch wait counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port f_req_valid  in  1  fetch read request pending.
REQ-007 SHALL have port f_req_ready  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port f_req_addr  in  ADDR_W  fetch read address.
REQ-009 SHALL have port f_resp_valid  out  1  one-cycle pulse, resp_data belongs to fetch.
REQ-010 SHALL have port ls_req_valid  in  1  load/store request pending.
REQ-011 SHALL have port ls_req_ready  out  1  load/store request accepted this cycle.
REQ-012 SHALL have port ls_req_write  in  1  1 = write, 0 = read.
REQ-013 SHALL have port ls_req_addr  in  ADDR_W  load/store address.
REQ-014 SHALL have port ls_req_wdata  in  DATA_W  write payload.
REQ-015 SHALL have port ls_resp_valid  out  1  one-cycle pulse, resp_data belongs to load/store.
REQ-016 SHALL have port resp_data  out  DATA_W  returned payload, shared by both requesters.
REQ-017 SHALL have port mem_req_valid  out  1  request to memory bus.
REQ-018 SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-019 SHALL have port mem_req_write  out  1  write flag to memory.
REQ-020 SHALL have port mem_req_addr  out  ADDR_W  address to memory.
REQ-021 SHALL have port mem_req_wdata  out  DATA_W  write data to memory.
REQ-022 SHALL have port mem_resp_valid  in  1  memory response present (reads and writes each produce one).
REQ-023 SHALL have port mem_resp_data  in  DATA_W  memory response payload.
REQ-024 SHALL have port fetch_wait_cnt  out  CNT_W  cycles fetch waited ungranted.

Function
REQ-025 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP; at most one transaction outstanding.
REQ-026 In IDLE with any req_valid, SHALL assert winner's req_ready for exactly that cycle, latch addr/write/wdata/owner, go to ISSUE; req_ready SHALL be 0 in all other states.
REQ-027 Both valid in IDLE: winner SHALL be the requester not granted last (round-robin on last_owner); single valid always wins.
REQ-028 Fetch transactions SHALL drive mem_req_write=0 and mem_req_wdata=0; addresses SHALL pass unmodified.
REQ-029 In ISSUE, mem_req_valid=1 with latched fields held stable until mem_req_ready=1, then go to WAIT_RESP.
REQ-030 In WAIT_RESP, on mem_resp_valid SHALL register resp_data and pulse owner's resp_valid next cycle for one cycle, update last_owner, return to IDLE.
REQ-031 Minimum latency: accept at cycle N, mem_req_valid at N+1, resp_valid one cycle after mem_resp_valid.
REQ-032 mem_resp_valid outside WAIT_RESP SHALL be ignored with no output or state change.
REQ-033 fetch_wait_cnt SHALL increment each cycle f_req_valid=1 and f_req_ready=0, saturating at all-ones (no wrap).

Reset
REQ-034 On reset SHALL force IDLE, last_owner=load/store (fetch wins first tie), all outputs and fetch_wait_cnt to 0.
REQ-035 Reset mid-transaction SHALL abandon it; a subsequent stray response SHALL be dropped per REQ-032.

Configuration
REQ-036 With MEM_ARB_FETCH_PRIORITY_EN defined, fetch SHALL always win ties (fixed priority).
REQ-037 Without MEM_ARB_FETCH_PRIORITY_EN, arbitration SHALL be round-robin per REQ-027.

Verification
REQ-038 Fetch addr 0x40, mem_req_ready=1, mem_resp 0xDEADBEEF 3 cycles later -> one mem read at 0x40, f_resp_valid one cycle with 0xDEADBEEF, ls_resp_valid stays 0.
REQ-039 Both valid continuously after reset -> grants F,LS,F,LS; with MEM_ARB_FETCH_PRIORITY_EN -> F,F,F.
REQ-040 LS write addr 0x1000 wdata 0x55 with mem_req_ready low 5 cycles -> mem_req_valid/write=1/fields stable 5 cycles; concurrent fetch raises fetch_wait_cnt by 5 or more.
REQ-041 mem_resp_valid pulsed in IDLE -> no resp_valid pulse, state unchanged.
REQ-042 reset asserted in WAIT_RESP, response arrives after release -> outputs 0, response dropped, fetch_wait_cnt 0.
